register_load_sequencer: RTL

- Initiator side of the register-file load interface: accepts two 4-bit operands over a valid/ready input stream and drives operand data and LDA/LDB/LDO strobes into the register file.
- Waits a fixed execute latency for the datapath, then strobes the O register and returns the captured 8-bit result over a valid/ready output stream.
- Sits between the operand source (switches/host) and the register file/ALU datapath.

---
 rtl/register_load_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/register_load_sequencer.sv
// Register-file load sequencer: collects two operands over a valid/ready stream, strobes
// LDA/LDB, waits a fixed execute latency, strobes LDO and returns the captured result.
module register_load_sequencer #(
  parameter int INPUT_WIDTH  = 4,
  parameter int OUTPUT_WIDTH = 8,
  parameter int EXEC_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [INPUT_WIDTH-1:0]  a_data,
  output logic [INPUT_WIDTH-1:0]  b_data,
  output logic                    lda,
  output logic                    ldb,
  output logic                    ldo,
  input  logic [OUTPUT_WIDTH-1:0] o_data,
  output logic [OUTPUT_WIDTH-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy
);

  // Latencies below one cycle are clamped to one.
  localparam int         ExecEff = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam logic [3:0] CntLoad = 4'(ExecEff - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StWaitB,
    StLoadB,
    StExec,
    StLoadO,
    StCapture,
    StResult
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0]  a_q, a_d;
  logic [INPUT_WIDTH-1:0]  b_q, b_d;
  logic [OUTPUT_WIDTH-1:0] res_q, res_d;
  logic                    in_ready_q;
  logic                    lda_q, ldb_q, ldo_q;
  logic                    res_valid_q;
  logic                    busy_q;
  logic                    in_xfer;
  logic                    out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = res_valid_q && res_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          a_d     = in_data;
          state_d = StLoadA;
        end
      end
      StLoadA: state_d = StWaitB;
      StWaitB: begin
        if (in_xfer) begin
          b_d     = in_data;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        cnt_d   = CntLoad;
        state_d = StExec;
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StLoadO;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StLoadO: state_d = StCapture;
      StCapture: begin
        // O register was written by the LDO strobe one cycle earlier.
        res_d   = o_data;
        state_d = StResult;
      end
      StResult: begin
        if (out_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered so they align with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      lda_q       <= 1'b0;
      ldb_q       <= 1'b0;
      ldo_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      in_ready_q  <= (state_d == StIdle) || (state_d == StWaitB);
      lda_q       <= (state_d == StLoadA);
      ldb_q       <= (state_d == StLoadB);
      ldo_q       <= (state_d == StLoadO);
      res_valid_q <= (state_d == StResult);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign in_ready  = in_ready_q;
  assign a_data    = a_q;
  assign b_data    = b_q;
  assign lda       = lda_q;
  assign ldb       = ldb_q;
  assign ldo       = ldo_q;
  assign res_data  = res_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({lda, ldb, ldo}));

  a_res_stable: assert property (@(posedge clk) disable iff (!reset)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data)));

endmodule
